// File: rtl/up_csr_irq_bank.sv
// ---------------------------------------------------------------------------
// up_csr_irq_bank
//
// Microprocessor-port slave containing a small CSR bank:
//   addr 0             ID (read-only constant ID_VALUE)
//   addr 1             IRQ_STATUS (sticky, write-1-to-clear)
//   addr 2             IRQ_MASK   (read/write)
//   addr 3             IRQ_CTRL   (read/write, bit0 = global interrupt enable)
//   addr 4             IRQ_COUNT  (only when UP_CSR_IRQ_COUNT_EN is defined)
//   GP_BASE..+NUM_GP-1 general-purpose registers (GP_BASE = 4, or 5 with the counter)
// Unmapped addresses read as zero and ignore writes.
//
// Reads are registered: a qualified read in cycle N presents pi_rd_data with a
// one-cycle pi_rd_valid pulse in cycle N+1. A read and a write in the same
// cycle return the value held before the write.
//
// The interrupt request is driven by a three-state handshake FSM
// (IDLE -> REQ -> ACKED -> IDLE) from pending = |(STATUS & MASK) & CTRL[0].
//
// Optional feature macro: UP_CSR_IRQ_COUNT_EN
//   Adds a saturating IRQ_COUNT register at address 4 that counts REQ->ACKED
//   handshakes; any write to it clears it (the clear beats a same-cycle count).
//
// Ports
//   clk            clock, rising edge
//   rst            asynchronous reset, active high
//   pi_blk_sel     block select qualifying pi_wr_en / pi_rd_en
//   pi_wr_en       write strobe
//   pi_rd_en       read strobe
//   pi_addr        word address [AW]
//   pi_wr_data     write data [DW]
//   pi_rd_data     registered read data [DW]
//   pi_rd_valid    one-cycle read-data-valid pulse
//   irq_src        interrupt event inputs [NUM_IRQ]
//   interrupt      registered interrupt request to host
//   interrupt_ack  host acknowledge (level)
//   gp_out         GP registers concatenated, GP[0] in the LSBs [NUM_GP*DW]
// ---------------------------------------------------------------------------
module up_csr_irq_bank #(
    parameter int          DW       = 8,
    parameter int          AW       = 4,
    parameter int          NUM_IRQ  = 4,
    parameter int          NUM_GP   = 4,
    parameter logic [31:0] ID_VALUE = 32'h0000_00A5
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 pi_blk_sel,
    input  logic                 pi_wr_en,
    input  logic                 pi_rd_en,
    input  logic [AW-1:0]        pi_addr,
    input  logic [DW-1:0]        pi_wr_data,
    output logic [DW-1:0]        pi_rd_data,
    output logic                 pi_rd_valid,
    input  logic [NUM_IRQ-1:0]   irq_src,
    output logic                 interrupt,
    input  logic                 interrupt_ack,
    output logic [NUM_GP*DW-1:0] gp_out
);

`ifdef UP_CSR_IRQ_COUNT_EN
    localparam int GP_BASE = 5;
    localparam logic [AW-1:0] ADDR_COUNT = AW'(4);
`else
    localparam int GP_BASE = 4;
`endif

    localparam logic [AW-1:0] ADDR_ID     = AW'(0);
    localparam logic [AW-1:0] ADDR_STATUS = AW'(1);
    localparam logic [AW-1:0] ADDR_MASK   = AW'(2);
    localparam logic [AW-1:0] ADDR_CTRL   = AW'(3);
    localparam logic [DW-1:0] ID_WORD     = DW'(ID_VALUE);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_REQ   = 2'd1,
        ST_ACKED = 2'd2
    } irq_state_t;

    // Register state
    logic [NUM_IRQ-1:0] status_r;
    logic [NUM_IRQ-1:0] mask_r;
    logic               ctrl_en_r;
    logic [DW-1:0]      gp_r [NUM_GP];
    irq_state_t         state_r;

    // Combinational helpers
    logic               wr_s;
    logic               rd_s;
    logic [NUM_IRQ-1:0] status_next_s;
    logic               pending_s;
    irq_state_t         state_next_s;
    logic [DW-1:0]      gp_rd_s;
    logic [DW-1:0]      rd_word_s;

    assign wr_s = pi_blk_sel & pi_wr_en;
    assign rd_s = pi_blk_sel & pi_rd_en;

    assign pending_s = ctrl_en_r & (|(status_r & mask_r));

`ifdef UP_CSR_IRQ_COUNT_EN
    logic [DW-1:0] irq_count_r;
    logic          ack_event_s;

    // A handshake completes on the edge that moves REQ to ACKED.
    assign ack_event_s = (state_r == ST_REQ) & interrupt_ack;

    // Saturating handshake counter; a host write clears it and beats an increment.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            irq_count_r <= '0;
        end else if (wr_s && (pi_addr == ADDR_COUNT)) begin
            irq_count_r <= '0;
        end else if (ack_event_s && (irq_count_r != {DW{1'b1}})) begin
            irq_count_r <= irq_count_r + DW'(1);
        end else begin
            irq_count_r <= irq_count_r;
        end
    end
`endif

    // Sticky status: new events are ORed in after the W1C, so a same-cycle set wins.
    always_comb begin
        status_next_s = status_r;
        if (wr_s && (pi_addr == ADDR_STATUS)) begin
            status_next_s = (status_r & ~pi_wr_data[NUM_IRQ-1:0]) | irq_src;
        end else begin
            status_next_s = status_r | irq_src;
        end
    end

    // Status, mask and control registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            status_r  <= '0;
            mask_r    <= '0;
            ctrl_en_r <= 1'b0;
        end else begin
            status_r <= status_next_s;
            if (wr_s && (pi_addr == ADDR_MASK)) begin
                mask_r <= pi_wr_data[NUM_IRQ-1:0];
            end else begin
                mask_r <= mask_r;
            end
            if (wr_s && (pi_addr == ADDR_CTRL)) begin
                ctrl_en_r <= pi_wr_data[0];
            end else begin
                ctrl_en_r <= ctrl_en_r;
            end
        end
    end

    // General-purpose registers, one address each starting at GP_BASE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_GP; i++) begin
                gp_r[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_GP; i++) begin
                if (wr_s && (pi_addr == AW'(GP_BASE + i))) begin
                    gp_r[i] <= pi_wr_data;
                end else begin
                    gp_r[i] <= gp_r[i];
                end
            end
        end
    end

    genvar g;
    generate
        for (g = 0; g < NUM_GP; g++) begin : g_gp_out
            assign gp_out[g*DW +: DW] = gp_r[g];
        end
    endgenerate

    // GP read decode; addresses outside the GP window fall through to zero.
    always_comb begin
        gp_rd_s = '0;
        for (int i = 0; i < NUM_GP; i++) begin
            gp_rd_s = (pi_addr == AW'(GP_BASE + i)) ? gp_r[i] : gp_rd_s;
        end
    end

    // Read mux over current (pre-write) register contents; narrow fields zero-extended.
    always_comb begin
        rd_word_s = '0;
        case (pi_addr)
            ADDR_ID:     rd_word_s = ID_WORD;
            ADDR_STATUS: rd_word_s[NUM_IRQ-1:0] = status_r;
            ADDR_MASK:   rd_word_s[NUM_IRQ-1:0] = mask_r;
            ADDR_CTRL:   rd_word_s[0] = ctrl_en_r;
`ifdef UP_CSR_IRQ_COUNT_EN
            ADDR_COUNT:  rd_word_s = irq_count_r;
`endif
            default:     rd_word_s = gp_rd_s;
        endcase
    end

    // Registered read port: data updates only on a read, valid pulses for one cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pi_rd_data  <= '0;
            pi_rd_valid <= 1'b0;
        end else begin
            pi_rd_valid <= rd_s;
            if (rd_s) begin
                pi_rd_data <= rd_word_s;
            end else begin
                pi_rd_data <= pi_rd_data;
            end
        end
    end

    // Handshake FSM next state; ack outranks withdrawal while requesting.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (pending_s) begin
                    state_next_s = ST_REQ;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_REQ: begin
                if (interrupt_ack) begin
                    state_next_s = ST_ACKED;
                end else if (!pending_s) begin
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = ST_REQ;
                end
            end
            ST_ACKED: begin
                if (!interrupt_ack) begin
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = ST_ACKED;
                end
            end
            default: state_next_s = ST_IDLE;
        endcase
    end

    // FSM state plus the interrupt output, registered from the next state so it tracks REQ exactly.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r   <= ST_IDLE;
            interrupt <= 1'b0;
        end else begin
            state_r   <= state_next_s;
            interrupt <= (state_next_s == ST_REQ);
        end
    end

endmodule

// File: tb/tb_up_csr_irq_bank.sv
// Self-checking bench for up_csr_irq_bank (default parameters).
module tb_up_csr_irq_bank;

`ifdef UP_CSR_IRQ_COUNT_EN
    localparam int GPB = 5;
`else
    localparam int GPB = 4;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        pi_blk_sel, pi_wr_en, pi_rd_en;
    logic [3:0]  pi_addr;
    logic [7:0]  pi_wr_data;
    logic [7:0]  pi_rd_data;
    logic        pi_rd_valid;
    logic [3:0]  irq_src;
    logic        interrupt;
    logic        interrupt_ack;
    logic [31:0] gp_out;

    int n_checks = 0;
    int n_err    = 0;

    up_csr_irq_bank dut (
        .clk(clk), .rst(rst),
        .pi_blk_sel(pi_blk_sel), .pi_wr_en(pi_wr_en), .pi_rd_en(pi_rd_en),
        .pi_addr(pi_addr), .pi_wr_data(pi_wr_data),
        .pi_rd_data(pi_rd_data), .pi_rd_valid(pi_rd_valid),
        .irq_src(irq_src), .interrupt(interrupt), .interrupt_ack(interrupt_ack),
        .gp_out(gp_out)
    );

    always #5 clk = ~clk;

    // ---------------- reference model (host-visible behaviour) ----------------
    logic [7:0] m_gp [4];
    logic [3:0] m_status, m_mask;
    logic       m_en;
    logic       m_requesting;   // interrupt line is up
    logic       m_wait_release; // acked, waiting for host to drop ack
    logic [7:0] m_count;
    logic [7:0] m_rd;
    logic       m_valid;

    task automatic model_reset();
        for (int i = 0; i < 4; i++) m_gp[i] = 8'h00;
        m_status = 4'h0; m_mask = 4'h0; m_en = 1'b0;
        m_requesting = 1'b0; m_wait_release = 1'b0;
        m_count = 8'h00; m_rd = 8'h00; m_valid = 1'b0;
    endtask

    function automatic logic [7:0] model_read(input logic [3:0] a);
        int ia;
        ia = int'(a);
        if (ia == 0) return 8'hA5;
        if (ia == 1) return {4'h0, m_status};
        if (ia == 2) return {4'h0, m_mask};
        if (ia == 3) return {7'h00, m_en};
`ifdef UP_CSR_IRQ_COUNT_EN
        if (ia == 4) return m_count;
`endif
        if (ia >= GPB && ia < GPB + 4) return m_gp[ia - GPB];
        return 8'h00;
    endfunction

    // Advance one clock edge with the current inputs, then update the model.
    task automatic step();
        logic do_wr, do_rd, pend;
        do_wr = pi_blk_sel & pi_wr_en;
        do_rd = pi_blk_sel & pi_rd_en;
        pend  = m_en && ((m_status & m_mask) != 4'h0);
        @(posedge clk);
        m_valid = do_rd;
        if (do_rd) m_rd = model_read(pi_addr);
        if (m_requesting) begin
            if (interrupt_ack) begin
                m_requesting = 1'b0; m_wait_release = 1'b1;
                if (m_count != 8'hFF) m_count = m_count + 8'd1;
            end else if (!pend) begin
                m_requesting = 1'b0;
            end
        end else if (m_wait_release) begin
            if (!interrupt_ack) m_wait_release = 1'b0;
        end else if (pend) begin
            m_requesting = 1'b1;
        end
        if (do_wr) begin
            if (pi_addr == 4'd1) m_status = m_status & ~pi_wr_data[3:0];
            if (pi_addr == 4'd2) m_mask = pi_wr_data[3:0];
            if (pi_addr == 4'd3) m_en = pi_wr_data[0];
`ifdef UP_CSR_IRQ_COUNT_EN
            if (pi_addr == 4'd4) m_count = 8'h00;
`endif
            if (int'(pi_addr) >= GPB && int'(pi_addr) < GPB + 4) m_gp[int'(pi_addr) - GPB] = pi_wr_data;
        end
        m_status = m_status | irq_src;
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_model();
        check("rnd_valid", {31'd0, pi_rd_valid}, {31'd0, m_valid});
        check("rnd_rd_data", {24'd0, pi_rd_data}, {24'd0, m_rd});
        check("rnd_interrupt", {31'd0, interrupt}, {31'd0, m_requesting});
        check("rnd_gp_out", gp_out, {m_gp[3], m_gp[2], m_gp[1], m_gp[0]});
    endtask

    task automatic drive(input logic s, input logic w, input logic r, input logic [3:0] a,
                         input logic [7:0] d, input logic [3:0] q, input logic k);
        pi_blk_sel = s; pi_wr_en = w; pi_rd_en = r; pi_addr = a;
        pi_wr_data = d; irq_src = q; interrupt_ack = k;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 1'b0, 4'd0, 8'h00, 4'h0, interrupt_ack);
    endtask

    typedef struct {
        logic       sel, wr, rd;
        logic [3:0] addr;
        logic [7:0] wd;
        logic [3:0] irq;
        logic       ack;
        logic       exp_valid;
        logic [7:0] exp_rd;
        logic       exp_int;
    } vec_t;

    vec_t vecs[18];

    initial begin
        logic [3:0] gp1;
        gp1 = 4'(GPB + 1);
        vecs[0]  = '{1'b1, 1'b0, 1'b1, 4'd0,  8'h00, 4'h0, 1'b0, 1'b1, 8'hA5, 1'b0};
        vecs[1]  = '{1'b1, 1'b1, 1'b0, gp1,   8'h3C, 4'h0, 1'b0, 1'b0, 8'hA5, 1'b0};
        vecs[2]  = '{1'b1, 1'b0, 1'b1, gp1,   8'h00, 4'h0, 1'b0, 1'b1, 8'h3C, 1'b0};
        vecs[3]  = '{1'b1, 1'b0, 1'b1, 4'd15, 8'h00, 4'h0, 1'b0, 1'b1, 8'h00, 1'b0};
        vecs[4]  = '{1'b1, 1'b1, 1'b1, 4'd2,  8'h05, 4'h0, 1'b0, 1'b1, 8'h00, 1'b0};
        vecs[5]  = '{1'b1, 1'b0, 1'b1, 4'd2,  8'h00, 4'h0, 1'b0, 1'b1, 8'h05, 1'b0};
        vecs[6]  = '{1'b1, 1'b1, 1'b0, 4'd3,  8'h01, 4'h0, 1'b0, 1'b0, 8'h05, 1'b0};
        vecs[7]  = '{1'b0, 1'b0, 1'b0, 4'd0,  8'h00, 4'h4, 1'b0, 1'b0, 8'h05, 1'b0};
        vecs[8]  = '{1'b0, 1'b0, 1'b0, 4'd0,  8'h00, 4'h0, 1'b0, 1'b0, 8'h05, 1'b1};
        vecs[9]  = '{1'b1, 1'b0, 1'b1, 4'd1,  8'h00, 4'h0, 1'b0, 1'b1, 8'h04, 1'b1};
        vecs[10] = '{1'b0, 1'b0, 1'b0, 4'd0,  8'h00, 4'h0, 1'b1, 1'b0, 8'h04, 1'b0};
        vecs[11] = '{1'b0, 1'b0, 1'b0, 4'd0,  8'h00, 4'h0, 1'b1, 1'b0, 8'h04, 1'b0};
        vecs[12] = '{1'b1, 1'b1, 1'b0, 4'd1,  8'h04, 4'h0, 1'b0, 1'b0, 8'h04, 1'b0};
        vecs[13] = '{1'b1, 1'b0, 1'b1, 4'd1,  8'h00, 4'h0, 1'b0, 1'b1, 8'h00, 1'b0};
        vecs[14] = '{1'b1, 1'b1, 1'b0, 4'd1,  8'h01, 4'h1, 1'b0, 1'b0, 8'h00, 1'b0};
        vecs[15] = '{1'b1, 1'b1, 1'b1, 4'd1,  8'h01, 4'h0, 1'b0, 1'b1, 8'h01, 1'b1};
        vecs[16] = '{1'b0, 1'b0, 1'b0, 4'd0,  8'h00, 4'h0, 1'b0, 1'b0, 8'h01, 1'b0};
        vecs[17] = '{1'b1, 1'b0, 1'b1, 4'd1,  8'h00, 4'h0, 1'b0, 1'b1, 8'h00, 1'b0};

        // ---- reset state ----
        rst = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 4'd0, 8'h00, 4'h0, 1'b0);
        model_reset();
        #12 rst = 1'b0;
        check("reset_rd_valid", {31'd0, pi_rd_valid}, 32'd0);
        check("reset_rd_data", {24'd0, pi_rd_data}, 32'd0);
        check("reset_interrupt", {31'd0, interrupt}, 32'd0);
        check("reset_gp_out", gp_out, 32'd0);

        // ---- table-driven directed vectors ----
        for (int i = 0; i < 18; i++) begin
            drive(vecs[i].sel, vecs[i].wr, vecs[i].rd, vecs[i].addr, vecs[i].wd, vecs[i].irq, vecs[i].ack);
            step();
            check($sformatf("vec%0d_valid", i), {31'd0, pi_rd_valid}, {31'd0, vecs[i].exp_valid});
            check($sformatf("vec%0d_rd_data", i), {24'd0, pi_rd_data}, {24'd0, vecs[i].exp_rd});
            check($sformatf("vec%0d_interrupt", i), {31'd0, interrupt}, {31'd0, vecs[i].exp_int});
        end
        idle(); step();
        check("gp1_on_gp_out", {24'd0, gp_out[15:8]}, 32'h3C);

        // ---- masked source, then request withdrawn by clearing the mask ----
        drive(1'b1, 1'b1, 1'b0, 4'd2, 8'h00, 4'h0, 1'b0); step();
        drive(1'b0, 1'b0, 1'b0, 4'd0, 8'h00, 4'h2, 1'b0); step();
        drive(1'b1, 1'b0, 1'b1, 4'd1, 8'h00, 4'h0, 1'b0); step();
        check("masked_status", {24'd0, pi_rd_data}, 32'h02);
        check("masked_no_int", {31'd0, interrupt}, 32'd0);
        drive(1'b1, 1'b1, 1'b0, 4'd2, 8'h02, 4'h0, 1'b0); step();
        check("unmask_int_not_yet", {31'd0, interrupt}, 32'd0);
        idle(); step();
        check("unmask_int_high", {31'd0, interrupt}, 32'd1);
        drive(1'b1, 1'b1, 1'b0, 4'd2, 8'h00, 4'h0, 1'b0); step();
        check("mask_clr_int_still", {31'd0, interrupt}, 32'd1);
        idle(); step();
        check("withdraw_int_low", {31'd0, interrupt}, 32'd0);
        idle(); step();
        check("withdraw_stays_low", {31'd0, interrupt}, 32'd0);
        drive(1'b1, 1'b1, 1'b0, 4'd1, 8'h0F, 4'h0, 1'b0); step();

        // ---- randomized traffic against the model ----
        for (int c = 0; c < 600; c++) begin
            pi_blk_sel = ($urandom_range(0, 3) != 0);
            pi_wr_en   = ($urandom_range(0, 2) == 0);
            pi_rd_en   = ($urandom_range(0, 1) == 0);
            pi_addr    = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 8));
            pi_wr_data = 8'($urandom);
            irq_src    = ($urandom_range(0, 5) == 0) ? 4'($urandom) : 4'h0;
            if ($urandom_range(0, 3) == 0) interrupt_ack = ~interrupt_ack;
            step();
            check_model();
        end

        // ---- async reset in the middle of a read ----
        drive(1'b1, 1'b0, 1'b1, 4'd0, 8'h00, 4'h0, 1'b0);
        #3 rst = 1'b1;
        #1;
        check("midrst_rd_valid", {31'd0, pi_rd_valid}, 32'd0);
        check("midrst_rd_data", {24'd0, pi_rd_data}, 32'd0);
        check("midrst_interrupt", {31'd0, interrupt}, 32'd0);
        check("midrst_gp_out", gp_out, 32'd0);
        @(posedge clk); #1;
        check("midrst_no_valid_pulse", {31'd0, pi_rd_valid}, 32'd0);
        idle();
        rst = 1'b0;
        model_reset();
        drive(1'b1, 1'b0, 1'b1, 4'd0, 8'h00, 4'h0, 1'b0); step();
        check("post_rst_id_valid", {31'd0, pi_rd_valid}, 32'd1);
        check("post_rst_id", {24'd0, pi_rd_data}, 32'hA5);
        idle(); step();
        check("post_rst_valid_drop", {31'd0, pi_rd_valid}, 32'd0);

`ifdef UP_CSR_IRQ_COUNT_EN
        // ---- handshake counter ----
        drive(1'b1, 1'b1, 1'b0, 4'd2, 8'h01, 4'h0, 1'b0); step();
        drive(1'b1, 1'b1, 1'b0, 4'd3, 8'h01, 4'h0, 1'b0); step();
        for (int k = 0; k < 3; k++) begin
            drive(1'b0, 1'b0, 1'b0, 4'd0, 8'h00, 4'h1, 1'b0); step();
            idle(); step();
            check("cnt_int_high", {31'd0, interrupt}, 32'd1);
            drive(1'b1, 1'b1, 1'b0, 4'd1, 8'h01, 4'h0, 1'b1); step();
            drive(1'b0, 1'b0, 1'b0, 4'd0, 8'h00, 4'h0, 1'b0); step();
        end
        drive(1'b1, 1'b0, 1'b1, 4'd4, 8'h00, 4'h0, 1'b0); step();
        check("irq_count_3", {24'd0, pi_rd_data}, 32'd3);
        drive(1'b1, 1'b1, 1'b0, 4'd4, 8'h77, 4'h0, 1'b0); step();
        drive(1'b1, 1'b0, 1'b1, 4'd4, 8'h00, 4'h0, 1'b0); step();
        check("irq_count_cleared", {24'd0, pi_rd_data}, 32'd0);
        drive(1'b1, 1'b1, 1'b0, 4'd5, 8'h5A, 4'h0, 1'b0); step();
        check("gp0_at_addr5", {24'd0, gp_out[7:0]}, 32'h5A);
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
